// File: rtl/key_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_pkg: shared types and width helpers for the keypad scanner
// Rev 1.0
// ---------------------------------------------------------------------------
package key_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2
    } scan_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int code_width(input int rows, input int cols);
        return clog2_min1(rows * cols);
    endfunction

    localparam int KEY_ROWS   = 4;
    localparam int KEY_COLS   = 4;
    localparam int KEY_CODE_W = code_width(KEY_ROWS, KEY_COLS);

    typedef struct packed {
        logic [KEY_CODE_W-1:0] code;
        logic                  press;
    } key_event_t;

endpackage
`default_nettype wire

// File: rtl/key_matrix_scan_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_matrix_scan_if: valid/ready key event port
// Rev 1.0
// ---------------------------------------------------------------------------
interface key_matrix_scan_if #(
    parameter int CODE_W = 4
);
    logic              ev_valid;
    logic              ev_ready;
    logic [CODE_W-1:0] ev_code;
    logic              ev_press;

    modport master (output ev_valid, output ev_code, output ev_press, input ev_ready);
    modport slave  (input ev_valid, input ev_code, input ev_press, output ev_ready);
endinterface
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_event_fifo: small FIFO of key events; a full FIFO accepts a push when popped
// Rev 1.0
// ---------------------------------------------------------------------------
module key_event_fifo
    import key_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = key_event_t
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic push_i,
    input  wire T     din_i,
    output logic      full_o,
    input  wire logic pop_i,
    output T          dout_o,
    output logic      empty_o
);
    localparam int AW = clog2_min1(DEPTH);

    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    T            mem_q [DEPTH];
    logic        w_wr;
    logic        w_rd;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign w_rd    = pop_i && !empty_o;
    assign w_wr    = push_i && (!full_o || w_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (w_wr) wr_q <= wr_q + 1'b1;
            if (w_rd) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) mem_q[wr_q[AW-1:0]] <= din_i;
    end

    // Head reads as zero when empty so the outputs have a defined reset value.
    always_comb begin
        dout_o = T'('0);
        if (!empty_o) dout_o = mem_q[rd_q[AW-1:0]];
    end

endmodule
`default_nettype wire

// File: rtl/key_matrix_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_matrix_scan: column-scanned keypad with one time-shared debouncer
// Rev 1.0
// ---------------------------------------------------------------------------
module key_matrix_scan
    import key_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SETTLE_CYCLES  = 100,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int QDEPTH         = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    output logic [COLS-1:0]           col_n_o,
    input  wire logic [ROWS-1:0]      row_n_i,
    output logic [ROWS*COLS-1:0]      key_state_o,
    output logic                      overflow_o,
    key_matrix_scan_if.master         ev
);
    localparam int KEYS   = ROWS * COLS;
    localparam int CODE_W = code_width(ROWS, COLS);
    localparam int RW     = clog2_min1(ROWS);
    localparam int CW     = clog2_min1(COLS);
    localparam int SW     = clog2_min1(SETTLE_CYCLES);
    localparam int NW     = clog2_min1(DEBOUNCE_SCANS);

    logic [ROWS-1:0]   row_meta_q;
    logic [ROWS-1:0]   row_sync_q;
    logic [ROWS-1:0]   rowcap_q;
    scan_state_t       state_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_idx_q;
    logic [SW-1:0]     settle_q;
    logic [COLS-1:0]   col_n_q;
    logic [KEYS-1:0]   key_state_q;
    logic [NW-1:0]     cnt_q [KEYS];
    logic              overflow_q;

    logic [CODE_W-1:0] w_key;
    logic [CW-1:0]     w_col_nxt;
    logic              w_bit;
    logic              w_cur;
    logic [NW-1:0]     w_cnt;
    logic [NW-1:0]     cnt_d;
    logic              key_d;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    key_event_t        w_ev;
    key_event_t        w_head;

    assign w_key     = CODE_W'(int'(row_idx_q) * COLS + int'(col_q));
    assign w_col_nxt = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
    assign w_bit     = rowcap_q[row_idx_q];
    assign w_cur     = key_state_q[w_key];
    assign w_cnt     = cnt_q[w_key];

    // Debounce step for the key currently selected by (row_idx_q, col_q).
    always_comb begin
        cnt_d  = w_cnt + 1'b1;
        key_d  = w_cur;
        w_push = 1'b0;
        if (w_bit == w_cur) begin
            cnt_d = '0;
        end else if (w_cnt == NW'(DEBOUNCE_SCANS - 1)) begin
            cnt_d  = '0;
            key_d  = w_bit;
            w_push = (state_q == SAMPLE);
        end
    end

    always_comb begin
        w_ev       = '0;
        w_ev.code  = KEY_CODE_W'(w_key);
        w_ev.press = w_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q  <= '1;
            row_sync_q  <= '1;
            rowcap_q    <= '0;
            state_q     <= IDLE;
            col_q       <= '0;
            row_idx_q   <= '0;
            settle_q    <= '0;
            col_n_q     <= '1;
            key_state_q <= '0;
            overflow_q  <= 1'b0;
            for (int k = 0; k < KEYS; k++) cnt_q[k] <= '0;
        end else begin
            row_meta_q <= row_n_i;
            row_sync_q <= row_meta_q;
            if (w_push && w_full && !w_pop) overflow_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    state_q  <= DRIVE;
                    col_q    <= '0;
                    settle_q <= '0;
                    col_n_q  <= ~COLS'(1);
                end
                DRIVE: begin
                    if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                        rowcap_q  <= ~row_sync_q;
                        row_idx_q <= '0;
                        state_q   <= SAMPLE;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    cnt_q[w_key]       <= cnt_d;
                    key_state_q[w_key] <= key_d;
                    if (row_idx_q == RW'(ROWS - 1)) begin
                        col_q    <= w_col_nxt;
                        col_n_q  <= ~(COLS'(1) << w_col_nxt);
                        settle_q <= '0;
                        state_q  <= DRIVE;
                    end else begin
                        row_idx_q <= row_idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    key_event_fifo #(
        .DEPTH (QDEPTH),
        .T     (key_event_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .din_i   (w_ev),
        .full_o  (w_full),
        .pop_i   (w_pop),
        .dout_o  (w_head),
        .empty_o (w_empty)
    );

    assign w_pop       = ev.ev_valid && ev.ev_ready;
    assign ev.ev_valid = !w_empty;
    assign ev.ev_code  = w_head.code;
    assign ev.ev_press = w_head.press;

    assign col_n_o     = col_n_q;
    assign key_state_o = key_state_q;
    assign overflow_o  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_key_matrix_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_key_matrix_scan: directed self-checking bench for key_matrix_scan
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_key_matrix_scan;
    localparam int T = 32;

    logic        clk;
    logic        rst;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] key_state;
    logic        overflow;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [4:0] ev_q[$];
    int         ev_cyc[$];

    key_matrix_scan_if #(.CODE_W(4)) ev_if ();

    key_matrix_scan #(
        .ROWS           (4),
        .COLS           (4),
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_SCANS (3),
        .QDEPTH         (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .col_n_o     (col_n),
        .row_n_i     (row_n),
        .key_state_o (key_state),
        .overflow_o  (overflow),
        .ev          (ev_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_n = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    always @(negedge clk) begin
        cyc++;
        if (ev_if.ev_valid && ev_if.ev_ready) begin
            ev_q.push_back({ev_if.ev_code, ev_if.ev_press});
            ev_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ev(input string tag, input int idx, input logic [3:0] code, input logic press);
        logic [31:0] obs;
        obs = (idx < ev_q.size()) ? {27'd0, ev_q[idx]} : 32'hFFFF_FFFF;
        check(tag, obs, {27'd0, code, press});
    endtask

    task automatic wait_col0();
        int n;
        n = 0;
        while (col_n !== 4'b1110 && n < 2*T) begin
            tick();
            n++;
        end
        check("col0 reached", {31'd0, col_n === 4'b1110}, 32'd1);
    endtask

    initial begin
        int first;
        logic saw;

        rst = 1'b1;
        pressed = '0;
        ev_if.ev_ready = 1'b0;

        // Reset and idle
        repeat (5) tick();
        check("rst col_n", {28'd0, col_n}, 32'hF);
        check("rst key_state", {16'd0, key_state}, 32'd0);
        check("rst ev_valid", {31'd0, ev_if.ev_valid}, 32'd0);
        check("rst ev_code", {28'd0, ev_if.ev_code}, 32'd0);
        check("rst ev_press", {31'd0, ev_if.ev_press}, 32'd0);
        check("rst overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        tick();
        tick();
        check("col0 after release", {28'd0, col_n}, 32'hE);
        saw = 1'b0;
        repeat (2000) begin
            tick();
            if (ev_if.ev_valid) saw = 1'b1;
        end
        check("idle no event", {31'd0, saw}, 32'd0);

        // Clean press and release of key 9 (row 2, column 1)
        ev_if.ev_ready = 1'b1;
        ev_q.delete();
        wait_col0();
        pressed[9] = 1'b1;
        first = 0;
        for (int n = 1; n <= 3*T+3; n++) begin
            tick();
            if (first == 0 && key_state[9]) first = n;
        end
        check("press9 within bound", {31'd0, first != 0}, 32'd1);
        check("press9 not early", {31'd0, first > 2*T}, 32'd1);
        repeat (200 - (3*T+3)) tick();
        check("press9 count", ev_q.size(), 32'd1);
        check_ev("press9 ev", 0, 4'd9, 1'b1);
        ev_q.delete();
        pressed[9] = 1'b0;
        repeat (4*T+10) tick();
        check("release9 count", ev_q.size(), 32'd1);
        check_ev("release9 ev", 0, 4'd9, 1'b0);
        check("release9 state", {16'd0, key_state}, 32'd0);

        // Bounce on key 5: alternating samples never debounce
        ev_q.delete();
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pressed[5] = ~pressed[5];
            repeat (T) begin
                tick();
                if (key_state != 16'd0) saw = 1'b1;
            end
        end
        pressed[5] = 1'b0;
        repeat (4*T) begin
            tick();
            if (key_state != 16'd0) saw = 1'b1;
        end
        check("bounce state", {31'd0, saw}, 32'd0);
        check("bounce events", ev_q.size(), 32'd0);

        // Simultaneous press of the whole column 0
        ev_q.delete();
        ev_cyc.delete();
        pressed[0] = 1'b1;
        pressed[4] = 1'b1;
        pressed[8] = 1'b1;
        pressed[12] = 1'b1;
        repeat (4*T) tick();
        check("col0 count", ev_q.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            check_ev("col0 ev", i, 4'(i*4), 1'b1);
        for (int i = 1; i < 4; i++)
            check("col0 consecutive", (i < ev_cyc.size()) ? ev_cyc[i] - ev_cyc[0] : -1, i);
        pressed = '0;
        repeat (4*T) tick();
        check("col0 released", {16'd0, key_state}, 32'd0);

        // Backpressure and overflow
        check("no overflow yet", {31'd0, overflow}, 32'd0);
        ev_if.ev_ready = 1'b0;
        ev_q.delete();
        wait_col0();
        pressed[1] = 1'b1;
        pressed[2] = 1'b1;
        pressed[3] = 1'b1;
        repeat (4*T) tick();
        wait_col0();
        pressed[1] = 1'b0;
        pressed[2] = 1'b0;
        pressed[3] = 1'b0;
        saw = 1'b0;
        repeat (4*T) begin
            tick();
            if (!ev_if.ev_valid || ev_if.ev_code !== 4'd1 || ev_if.ev_press !== 1'b1) saw = 1'b1;
        end
        check("bp head held", {31'd0, saw}, 32'd0);
        check("bp overflow", {31'd0, overflow}, 32'd1);
        check("bp key_state", {16'd0, key_state}, 32'd0);
        ev_if.ev_ready = 1'b1;
        repeat (10) tick();
        check("bp drain count", ev_q.size(), 32'd4);
        check_ev("bp ev0", 0, 4'd1, 1'b1);
        check_ev("bp ev1", 1, 4'd2, 1'b1);
        check_ev("bp ev2", 2, 4'd3, 1'b1);
        check_ev("bp ev3", 3, 4'd1, 1'b0);
        check("bp drained", {31'd0, ev_if.ev_valid}, 32'd0);

        // Reset in the middle of operation
        ev_if.ev_ready = 1'b0;
        pressed[6] = 1'b1;
        pressed[15] = 1'b1;
        repeat (4*T) tick();
        check("mid queued", {31'd0, ev_if.ev_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid rst ev_valid", {31'd0, ev_if.ev_valid}, 32'd0);
        check("mid rst key_state", {16'd0, key_state}, 32'd0);
        check("mid rst col_n", {28'd0, col_n}, 32'hF);
        check("mid rst overflow", {31'd0, overflow}, 32'd0);
        pressed[15] = 1'b0;
        repeat (3) tick();
        ev_q.delete();
        rst = 1'b0;
        ev_if.ev_ready = 1'b1;
        repeat (4*T+10) tick();
        check("re-report count", ev_q.size(), 32'd1);
        check_ev("re-report ev", 0, 4'd6, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_matrix_scan.md
# key_matrix_scan

Scans a ROWS x COLS passive keypad by driving one column low at a time and sampling the row lines. It time-shares a single debounce engine across all keys, keeping one small counter per key instead of instantiating one debouncer per key. Debounced press and release events are queued in a small FIFO and offered on a valid/ready port. It sits between the keypad pins and whatever consumes key events, such as a menu FSM or a UART reporter.

## Interface
- ROWS, 4, number of row inputs
- COLS, 4, number of column outputs
- SETTLE_CYCLES, 100, clock cycles a column is driven before its rows are captured; must be ≥ 3 to cover synchronizer latency
- DEBOUNCE_SCANS, 4, consecutive differing samples needed to change a key's debounced state; must be ≥ 2
- QDEPTH, 4, event FIFO depth; power of two
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- col_n  out  COLS  column drive, active low, at most one bit low
- row_n  in  ROWS  raw row sense, active low, pulled up, asynchronous to clk
- key_state  out  ROWS*COLS  debounced state per key, 1 = pressed, bit index = code
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts the head event
- ev_code  out  $clog2(ROWS*COLS)  key code of the head event, = row*COLS + col
- ev_press  out  1  1 = press, 0 = release
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full; cleared only by rst

## Operation
- row_n passes through a 2-flop synchronizer that resets to all ones.
- FSM states: IDLE, DRIVE, SAMPLE.
  - IDLE: one cycle after reset deassertion. Then go to DRIVE with col = 0.
  - DRIVE: col_n = ~(1 << col). Stay for SETTLE_CYCLES cycles. On the last cycle, latch the inverted synchronized rows into rowcap.
  - SAMPLE: lasts ROWS cycles. col_n is held, and cycle r processes key k = r*COLS + col. After the last cycle, col wraps COLS-1 → 0 and the FSM returns to DRIVE.
- Per-key debounce, applied when key k is processed, with counter cnt[k] of width $clog2(DEBOUNCE_SCANS):
  - If rowcap[r] == key_state[k]: cnt[k] ← 0.
  - Else if cnt[k] == DEBOUNCE_SCANS-1: key_state[k] ← rowcap[r], cnt[k] ← 0, push {k, rowcap[r]}.
  - Else: cnt[k] ← cnt[k] + 1.
- At most one push per cycle, by construction. Events for keys in the same column enter the FIFO in ascending row order.
- FIFO rules:
  - A pop happens when ev_valid && ev_ready.
  - When full, a push and a pop in the same cycle both succeed.
  - When full with no pop, a push is dropped and overflow ← 1; key_state still updates.
  - When empty, a push and a pop in the same cycle is impossible (no bypass).
- ev_code and ev_press stay stable while ev_valid=1 and ev_ready=0.

## Timing
- Reset values: col_n all ones; key_state 0; ev_valid 0; ev_code 0; ev_press 0; overflow 0; all counters 0; FIFO empty.
- col_n drives column 0 on the 2nd cycle after rst deasserts.
- Scan period T = COLS*(SETTLE_CYCLES+ROWS) cycles.
- A key that changes and stays stable produces its event between (DEBOUNCE_SCANS-1)*T+1 and DEBOUNCE_SCANS*T+3 cycles after the pin change.
- Push to ev_valid latency is 1 cycle.
- If rst asserts mid-scan or mid-handshake, all state is cleared immediately. Keys held through reset re-report as fresh presses after debounce.
- A bounce that reverts before DEBOUNCE_SCANS consecutive samples produces no event.

## Structure
- key_pkg holds:
  - the typedef enum for scan_state_t {IDLE, DRIVE, SAMPLE};
  - the packed struct key_event_t {code, press};
  - a localparam function that computes code width.
- Sub-module key_event_fifo: parameterized by depth and element type key_event_t; ports clk, rst, push, din, full, pop, dout, empty. The top level owns overflow.
- The top level contains the synchronizer, scan FSM, settle counter, per-key counter array and key_state.

## Test plan
Configuration for all scenarios: ROWS=COLS=4, SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, QDEPTH=4, so T=32.
- Reset and idle: hold rst for 5 cycles with row_n=4'b1111.
  - col_n must be 4'b1111 during reset and 4'b1110 on the 2nd cycle after release.
  - No ev_valid for 2000 cycles.
- Clean press: the keypad model pulls row_n[2] low whenever col_n[1] is low, held for 200 cycles with ev_ready=1.
  - Exactly one event: ev_code=9, ev_press=1; key_state[9]=1 within 3*T+3 cycles.
  - On release, one event: ev_code=9, ev_press=0.
- Bounce: key 5 pressed on alternate scans for 20 scans.
  - No events; key_state stays 0.
- Simultaneous: keys 0, 4, 8, 12 (all column 0) pressed together with ev_ready=1.
  - Four press events with codes 0, 4, 8, 12, in that order, on consecutive SAMPLE cycles.
- Backpressure/overflow: ev_ready=0; press then release keys 1, 2, 3 (6 events).
  - ev_valid stays 1 with the head held; overflow=1.
  - Raising ev_ready yields exactly 4 events in generation order (1↑, 2↑, 3↑, 1↓); key_state ends at 0.
- Reset mid-operation: key 6 held, 2 events queued, assert rst.
  - Same cycle: ev_valid=0, key_state=0, col_n=4'b1111.
  - After release with key 6 still held: one press event, code 6.
